scg_readap_brst: RTL and testbench
==================================

SCG_READAP_BRST -- requirements
Module: scg_readap_brst

Interface
REQ-001 SHALL have parameter CAS_LAT, default 2, meaning SDRAM CAS latency in clocks (legal range 1..3).
REQ-002 SHALL have parameter TRP_CYC, default 2, meaning precharge recovery clocks after the last data word (legal range 1..7).
REQ-003 SHALL have parameter DATA_W, default 16, meaning SDRAM data bus width.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  level request; held high until done is seen.
REQ-007 SHALL have port dq_in  input  DATA_W  SDRAM read data bus.
REQ-008 SHALL have port done  output  1  sequence complete; held while start is high.
REQ-009 SHALL have port chip  output  1  chip-select enable for the command/data window.
REQ-010 SHALL have port command  output  4  SDRAM command code.
REQ-011 SHALL have port rdata  output  DATA_W  last captured word, registered.
REQ-012 SHALL have port rvalid  output  1  one-cycle strobe per captured word.
REQ-013 SHALL have port rindex  output  2  burst index (0..3) of rdata.
REQ-014 SHALL have port line  output  4*DATA_W  assembled burst; word k at bits [k*DATA_W +: DATA_W].

Function
REQ-015 SHALL implement states IDLE, CMD, LAT, CAP, RECOV, DONE.
REQ-016 SHALL move from IDLE to CMD on the edge where start=1; otherwise it SHALL stay in IDLE.
REQ-017 SHALL spend exactly one cycle in CMD, driving command=CMD_READ_AP and chip=1.
REQ-018 SHALL spend CAS_LAT-1 cycles in LAT; when CAS_LAT=1, LAT SHALL be skipped (CMD goes directly to CAP).
REQ-019 SHALL spend exactly 4 cycles in CAP, capturing dq_in at the edge that ends each CAP cycle, in word order 0..3.
REQ-020 SHALL, for each capture, drive rdata=captured word, rindex=word number and rvalid=1 in the cycle after that capture.
REQ-021 SHALL write each captured word into its line slot at the same time it updates rdata; other slots SHALL be unchanged.
REQ-022 SHALL drive chip=1 in CMD, LAT and CAP, and chip=0 in all other states.
REQ-023 SHALL drive command=CMD_NOP in every state except CMD.
REQ-024 SHALL spend TRP_CYC cycles in RECOV, using a down-counter sized for 7.
REQ-025 SHALL then enter DONE with done=1, and SHALL stay in DONE while start=1.
REQ-026 SHALL return from DONE to IDLE on the edge where start=0; the next start=1 SHALL begin a new sequence.
REQ-027 SHALL ignore start=0 in CMD, LAT, CAP and RECOV; the sequence SHALL always complete.
REQ-028 SHALL hold line and rdata stable from the last capture until the next sequence overwrites them.
REQ-029 SHALL derive done, chip and command from registered state only, with no combinational path from start.
REQ-030 SHALL give start-sampled-to-done a latency of CAS_LAT+TRP_CYC+5 edges.

Reset
REQ-031 SHALL, while rst=1 at an edge, force state=IDLE, done=0, chip=0, command=CMD_NOP, rvalid=0, rindex=0, rdata=0, line=0, and clear all counters.
REQ-032 SHALL abort any in-flight sequence on rst; a mid-burst abort SHALL produce no further rvalid.
REQ-033 SHALL take precedence for rst over start when both are high.

Structure
REQ-034 SHALL take the command codes CMD_NOP=4'd0 and CMD_READ_AP=4'd5 and the state enum from the shared package scg_pkg, which the write-side generators also use.
REQ-035 SHALL place the cycle counters (LAT/RECOV) in one sub-module, scg_cnt, a loadable down-counter with a zero flag; the capture register stays in the top level.

Verification
REQ-036 SHALL cover a nominal read (CAS_LAT=2, TRP_CYC=2): start at cycle 0, dq_in=16'hA000+n -> command=5 at cycle 1 only; chip=1 cycles 1-6; rvalid cycles 4-7 with rdata A001..A004 (dq_in sampled at cycles 3-6); line=64'hA004_A003_A002_A001; done at cycle 9.
REQ-037 SHALL cover CAS_LAT=1: start at cycle 0 -> no LAT state; capture cycles 2-5; done at cycle 8.
REQ-038 SHALL cover early start release: start drops at cycle 3 -> burst completes; done pulses one cycle at 9; IDLE at 10.
REQ-039 SHALL cover a held start: start held through cycle 20 -> done stays 1 through cycle 20; IDLE follows the first low edge.
REQ-040 SHALL cover a mid-burst reset: rst=1 at cycle 5 -> cycle 6 all outputs at reset values, line=0, no further rvalid.
REQ-041 SHALL cover back-to-back sequences: start reasserted one cycle after IDLE -> second command=5, and the second line replaces the first word by word.

Source files
------------

// File: rtl/scg_pkg.sv
// Shared SDRAM command-generator package.
// Holds the command codes, the sequencer state enum and the cycle-counter
// width used by the read and write generators.
package scg_pkg;

    localparam logic [3:0] CMD_NOP     = 4'd0;
    localparam logic [3:0] CMD_READ_AP = 4'd5;

    // Wide enough for the longest precharge recovery (7 cycles).
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LAT   = 3'd2,
        ST_CAP   = 3'd3,
        ST_RECOV = 3'd4,
        ST_DONE  = 3'd5
    } scg_state_e;

endpackage

// File: rtl/scg_cnt.sv
// Loadable down-counter with zero flag, shared by the LAT and RECOV phases.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_load     - load i_val (takes priority over i_dec)
//   i_val      - load value
//   i_dec      - decrement by one
//   o_zero     - counter is zero
module scg_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)         r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_dec)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/scg_readap_brst.sv
// SDRAM READ-with-auto-precharge burst sequencer (burst length 4).
// Issues one READ_AP command, waits out CAS latency, captures four data
// words into rdata/line, waits precharge recovery, then raises done and
// holds it until start is released.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - level request, held until done
//   dq_in     - SDRAM read data
//   done      - sequence complete (held while start is high)
//   chip      - chip-select window (CMD, LAT, CAP)
//   command   - SDRAM command code
//   rdata     - last captured word; rindex its burst position
//   rvalid    - one-cycle strobe per captured word
//   line      - assembled burst, word k at [k*DATA_W +: DATA_W]
module scg_readap_brst
    import scg_pkg::*;
#(
    parameter int CAS_LAT = 2,
    parameter int TRP_CYC = 2,
    parameter int DATA_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     dq_in,
    output logic                  done,
    output logic                  chip,
    output logic [3:0]            command,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic [1:0]            rindex,
    output logic [4*DATA_W-1:0]   line
);

    // Counter holds "cycles remaining after this one", so a phase of N
    // cycles loads N-1. LAT lasts CAS_LAT-1 cycles, hence CAS_LAT-2.
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'((CAS_LAT > 1) ? CAS_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] RECOV_LOAD = CNT_W'(TRP_CYC - 1);

    scg_state_e                r_state;
    logic [1:0]                r_widx;
    logic [3:0][DATA_W-1:0]    r_line;
    logic                      r_done;
    logic                      r_chip;
    logic [3:0]                r_cmd;
    logic [DATA_W-1:0]         r_rdata;
    logic                      r_rvalid;
    logic [1:0]                r_rindex;

    logic                      w_load;
    logic [CNT_W-1:0]          w_load_val;
    logic                      w_dec;
    logic                      w_cnt_zero;

    // LAT is loaded on leaving CMD, RECOV on the last capture cycle.
    always_comb begin
        w_load     = (r_state == ST_CMD) || (r_state == ST_CAP && r_widx == 2'd3);
        w_load_val = (r_state == ST_CMD) ? LAT_LOAD : RECOV_LOAD;
        w_dec      = (r_state == ST_LAT || r_state == ST_RECOV) && !w_cnt_zero;
    end

    scg_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .i_dec  (w_dec),
        .o_zero (w_cnt_zero)
    );

    // Outputs are registered on the transition into the state that owns
    // them, so nothing downstream sees a combinational path from start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_widx   <= '0;
            r_line   <= '0;
            r_done   <= 1'b0;
            r_chip   <= 1'b0;
            r_cmd    <= CMD_NOP;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rindex <= '0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CMD;
                        r_chip  <= 1'b1;
                        r_cmd   <= CMD_READ_AP;
                    end
                end
                ST_CMD: begin
                    r_cmd   <= CMD_NOP;
                    r_state <= (CAS_LAT > 1) ? ST_LAT : ST_CAP;
                end
                ST_LAT: begin
                    if (w_cnt_zero) r_state <= ST_CAP;
                end
                ST_CAP: begin
                    r_line[r_widx] <= dq_in;
                    r_rdata        <= dq_in;
                    r_rindex       <= r_widx;
                    r_rvalid       <= 1'b1;
                    r_widx         <= r_widx + 2'd1;  // wraps to 0 for next burst
                    if (r_widx == 2'd3) begin
                        r_state <= ST_RECOV;
                        r_chip  <= 1'b0;
                    end
                end
                ST_RECOV: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done    = r_done;
    assign chip    = r_chip;
    assign command = r_cmd;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign rindex  = r_rindex;
    assign line    = r_line;

endmodule

// File: tb/tb_scg_readap_brst.sv
// Randomized + directed bench for scg_readap_brst. Three instances with
// different CAS/TRP share stimulus; each is checked every cycle against a
// timeline model: a sequence is a cycle count t since the command, and all
// outputs follow from where t sits relative to CAS_LAT and TRP_CYC.
module tb_scg_readap_brst;

    localparam int N = 3;
    localparam int CASV [N] = '{2, 1, 3};
    localparam int TRPV [N] = '{2, 2, 7};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dq_in;

    logic        done_a   [N];
    logic        chip_a   [N];
    logic [3:0]  command_a[N];
    logic [15:0] rdata_a  [N];
    logic        rvalid_a [N];
    logic [1:0]  rindex_a [N];
    logic [63:0] line_a   [N];

    always #5 clk = ~clk;

    scg_readap_brst #(.CAS_LAT(2), .TRP_CYC(2), .DATA_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .dq_in(dq_in),
        .done(done_a[0]), .chip(chip_a[0]), .command(command_a[0]),
        .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .rindex(rindex_a[0]), .line(line_a[0]));

    scg_readap_brst #(.CAS_LAT(1), .TRP_CYC(2), .DATA_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .dq_in(dq_in),
        .done(done_a[1]), .chip(chip_a[1]), .command(command_a[1]),
        .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .rindex(rindex_a[1]), .line(line_a[1]));

    scg_readap_brst #(.CAS_LAT(3), .TRP_CYC(7), .DATA_W(16)) dut2 (
        .clk(clk), .rst(rst), .start(start), .dq_in(dq_in),
        .done(done_a[2]), .chip(chip_a[2]), .command(command_a[2]),
        .rdata(rdata_a[2]), .rvalid(rvalid_a[2]), .rindex(rindex_a[2]), .line(line_a[2]));

    int vectors    = 0;
    int miscompares = 0;

    // model state: t=0 idle, t=1 command cycle, t=CAS+TRP+5 done
    int          m_t     [N];
    logic [15:0] m_line  [N][4];
    logic [15:0] m_rdata [N];
    logic [1:0]  m_rindex[N];
    logic        m_rvalid[N];

    task automatic chk(input string tag, input int inst, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t got=%h exp=%h", tag, inst, $time, got, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit s, input logic [15:0] d);
        int cas, dn;
        cas = CASV[i];
        dn  = CASV[i] + TRPV[i] + 5;
        if (r) begin
            m_t[i] = 0;
            for (int k = 0; k < 4; k++) m_line[i][k] = '0;
            m_rdata[i]  = '0;
            m_rindex[i] = '0;
            m_rvalid[i] = 1'b0;
        end else begin
            // capture window: t in CAS+1 .. CAS+4 -> word t-CAS-1
            if (m_t[i] >= cas + 1 && m_t[i] <= cas + 4) begin
                m_line[i][m_t[i]-cas-1] = d;
                m_rdata[i]  = d;
                m_rindex[i] = 2'(m_t[i] - cas - 1);
                m_rvalid[i] = 1'b1;
            end else begin
                m_rvalid[i] = 1'b0;
            end
            if (m_t[i] == 0)      m_t[i] = s ? 1 : 0;
            else if (m_t[i] < dn) m_t[i] = m_t[i] + 1;
            else if (!s)          m_t[i] = 0;
        end
    endtask

    task automatic check_inst(input int i);
        int cas, dn;
        cas = CASV[i];
        dn  = CASV[i] + TRPV[i] + 5;
        chk("done",    i, 64'(done_a[i]),    64'(m_t[i] == dn));
        chk("chip",    i, 64'(chip_a[i]),    64'(m_t[i] >= 1 && m_t[i] <= cas + 4));
        chk("command", i, 64'(command_a[i]), (m_t[i] == 1) ? 64'd5 : 64'd0);
        chk("rvalid",  i, 64'(rvalid_a[i]),  64'(m_rvalid[i]));
        chk("rindex",  i, 64'(rindex_a[i]),  64'(m_rindex[i]));
        chk("rdata",   i, 64'(rdata_a[i]),   64'(m_rdata[i]));
        chk("line",    i, line_a[i], {m_line[i][3], m_line[i][2], m_line[i][1], m_line[i][0]});
    endtask

    // Drive one cycle of inputs, advance model at the edge, check 1 ns later.
    task automatic step(input bit r, input bit s, input logic [15:0] d);
        rst = r; start = s; dq_in = d;
        @(posedge clk);
        for (int i = 0; i < N; i++) model_edge(i, r, s, d);
        #1;
        for (int i = 0; i < N; i++) check_inst(i);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dq_in = '0;
        for (int i = 0; i < N; i++) m_t[i] = 0;

        // reset, with start high to show reset dominates
        step(1, 0, 16'h1234);
        step(1, 1, 16'h5678);
        step(1, 0, 16'h0);

        // nominal read: word n of the burst appears as A000+n for CAS=2
        for (int n = 0; n < 12; n++) begin
            step(0, 1, 16'(32'hA000 + n - 2));
            if (n == 0) chk("nom_cmd_c1", 0, 64'(command_a[0]), 64'd5);
            if (n == 8) chk("nom_done_c9", 0, 64'(done_a[0]), 64'd1);
            if (n == 7) chk("cas1_done_c8", 1, 64'(done_a[1]), 64'd1);
        end
        for (int n = 0; n < 3; n++) step(0, 0, 16'h0);
        chk("nom_line", 0, line_a[0], 64'hA004_A003_A002_A001);

        // early release: start only in cycles 0-2
        for (int n = 0; n < 3; n++)  step(0, 1, 16'(32'hB000 + n));
        for (int n = 3; n < 22; n++) step(0, 0, 16'(32'hB000 + n));

        // held start through cycle 20
        for (int n = 0; n < 21; n++) step(0, 1, 16'(32'hC000 + n));
        for (int n = 0; n < 3; n++)  step(0, 0, 16'h0);

        // mid-burst reset at cycle 5
        for (int n = 0; n < 5; n++) step(0, 1, 16'(32'hD000 + n));
        step(1, 1, 16'hDEAD);
        chk("rst_line", 0, line_a[0], 64'd0);
        for (int n = 0; n < 8; n++) step(0, 0, 16'hBEEF);

        // back-to-back sequences
        for (int n = 0; n < 10; n++) step(0, 1, 16'(32'hE000 + n));
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        for (int n = 0; n < 10; n++) step(0, 1, 16'(32'hF000 + n));
        for (int n = 0; n < 20; n++) step(0, 0, 16'h0);

        // random: sticky start, rare reset
        begin
            bit s;
            s = 1'b0;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(7, 0) == 0) s = ~s;
                step(($urandom_range(79, 0) == 0), s, 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
